sdram_selftest: RTL and testbench



---
 rtl/sdram_selftest.sv | 273 +++++++++++++++++++++++++++
 tb/tb_sdram_selftest.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_selftest.sv
// -----------------------------------------------------------------------------
// sdram_selftest
// Built-in self-test for a 16-bit SDR SDRAM (4 banks, 8192 rows, 512 columns).
// A single-word controller handles power-up init, periodic auto-refresh, and
// single-word write/read with auto-precharge. The sequencer writes
// pattern(w) = w[15:0] ^ 16'hA5A5 to words 0..TEST_WORDS-1. It then reads the
// same words back and compares each one against the pattern.
//
// Ports
//   clk            single clock for the logic and the SDRAM
//   reset_n_i      asynchronous active-low reset
//   sdram_ba_o     bank address
//   sdram_a_o      row / column / mode address
//   sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o   command pins
//   sdram_dq_io    data bus, driven only during the WRITE cycle
//   sdram_dqm_o    byte masks (2'b11 until the mode register is set)
//   sdram_cke_o    clock enable
//   error_o        sticky read-compare failure
//   done_o         write and read passes complete
// -----------------------------------------------------------------------------
module sdram_selftest #(
    parameter int SDRAM_CLK_FREQ_MHZ = 100,
    parameter int INIT_US            = 100,
    parameter int TEST_WORDS         = 256
) (
    input  logic        clk,
    input  logic        reset_n_i,
    output logic [1:0]  sdram_ba_o,
    output logic [12:0] sdram_a_o,
    output logic        sdram_cs_n_o,
    output logic        sdram_ras_n_o,
    output logic        sdram_cas_n_o,
    output logic        sdram_we_n_o,
    inout  wire  [15:0] sdram_dq_io,
    output logic [1:0]  sdram_dqm_o,
    output logic        sdram_cke_o,
    output logic        error_o,
    output logic        done_o
);

    localparam int MHZ     = SDRAM_CLK_FREQ_MHZ;
    localparam int T_RP    = (20 * MHZ + 999) / 1000;
    localparam int T_RCD   = (20 * MHZ + 999) / 1000;
    localparam int T_RFC   = (70 * MHZ + 999) / 1000;
    localparam int T_WR    = 2;
    localparam int T_MRD   = 2;
    localparam int CL      = 2;
    localparam int T_INIT  = INIT_US * MHZ;
    localparam int T_REFI  = (7812 * MHZ) / 1000;
    localparam int CNT_W   = 24;

    // Wait counts are loaded with N-1: the command cycle itself is the first of N.
    localparam logic [CNT_W-1:0] C_INIT  = CNT_W'(T_INIT);
    localparam logic [CNT_W-1:0] C_RP    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] C_RCD   = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] C_RFC   = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] C_MRD   = CNT_W'(T_MRD - 1);
    localparam logic [CNT_W-1:0] C_WRREC = CNT_W'(T_WR + T_RP - 1);
    // Read recovery spans the CL+1 capture delay and the auto-precharge tRP.
    localparam logic [CNT_W-1:0] C_RDREC = CNT_W'(CL + T_RP);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [15:0]      C_REFI  = 16'(T_REFI - 1);
    localparam logic [23:0]      LAST_W  = 24'(TEST_WORDS - 1);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    typedef enum logic [3:0] {
        S_PWR, S_PRE, S_REF1, S_REF2, S_MRS, S_WAIT, S_IDLE, S_RW, S_NEXT
    } state_t;

    typedef enum logic [1:0] {PH_WR, PH_RD, PH_DONE} phase_t;

    function automatic logic [15:0] pattern(input logic [23:0] w);
        return w[15:0] ^ 16'hA5A5;
    endfunction

    state_t           state_q, state_d, ret_q, ret_d;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      w_q, w_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [1:0]       ba_q, ba_d;
    logic [12:0]      a_q, a_d;
    logic [1:0]       dqm_q, dqm_d;
    logic             cke_q;
    logic             dq_oe_q, dq_oe_d;
    logic [15:0]      dout_q, dout_d;
    logic [15:0]      exp_q, exp_d;
    logic [15:0]      rdata_q;
    logic [CL:0]      rd_sr_q;
    logic             cmp_vld_q;
    logic [15:0]      ref_cnt_q;
    logic             ref_run_q, ref_pend_q;
    logic             error_q, done_q;
    logic             ref_start, ref_clr, rd_start;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        w_d       = w_q;
        cmd_d     = CMD_NOP;
        ba_d      = '0;
        a_d       = '0;
        dqm_d     = dqm_q;
        dq_oe_d   = 1'b0;
        dout_d    = dout_q;
        exp_d     = exp_q;
        ref_start = 1'b0;
        ref_clr   = 1'b0;
        rd_start  = 1'b0;
        unique case (state_q)
            S_PWR: begin
                if (cnt_q <= C_ONE) state_d = S_PRE;
                else                cnt_d   = cnt_q - 1'b1;
            end
            S_PRE: begin
                cmd_d   = CMD_PRE;
                a_d[10] = 1'b1;
                cnt_d   = C_RP;
                ret_d   = S_REF1;
                state_d = S_WAIT;
            end
            S_REF1: begin
                cmd_d   = CMD_REF;
                cnt_d   = C_RFC;
                ret_d   = S_REF2;
                state_d = S_WAIT;
            end
            S_REF2: begin
                cmd_d   = CMD_REF;
                cnt_d   = C_RFC;
                ret_d   = S_MRS;
                state_d = S_WAIT;
            end
            S_MRS: begin
                cmd_d     = CMD_MRS;
                a_d       = 13'h020;
                dqm_d     = 2'b00;
                cnt_d     = C_MRD;
                ret_d     = S_IDLE;
                state_d   = S_WAIT;
                ref_start = 1'b1;
            end
            S_WAIT: begin
                if (cnt_q <= C_ONE) state_d = ret_q;
                else                cnt_d   = cnt_q - 1'b1;
            end
            S_IDLE: begin
                // Refresh is only ever started from IDLE, so it cannot split an access.
                if (ref_pend_q) begin
                    cmd_d   = CMD_REF;
                    ref_clr = 1'b1;
                    cnt_d   = C_RFC;
                    ret_d   = S_IDLE;
                    state_d = S_WAIT;
                end else if (phase_q != PH_DONE) begin
                    cmd_d   = CMD_ACT;
                    ba_d    = w_q[23:22];
                    a_d     = w_q[21:9];
                    cnt_d   = C_RCD;
                    ret_d   = S_RW;
                    state_d = S_WAIT;
                end
            end
            S_RW: begin
                ba_d    = w_q[23:22];
                a_d     = {4'b0010, w_q[8:0]};
                ret_d   = S_NEXT;
                state_d = S_WAIT;
                if (phase_q == PH_WR) begin
                    cmd_d   = CMD_WR;
                    dq_oe_d = 1'b1;
                    dout_d  = pattern(w_q);
                    cnt_d   = C_WRREC;
                end else begin
                    cmd_d    = CMD_RD;
                    rd_start = 1'b1;
                    exp_d    = pattern(w_q);
                    cnt_d    = C_RDREC;
                end
            end
            S_NEXT: begin
                state_d = S_IDLE;
                if (w_q == LAST_W) begin
                    w_d     = '0;
                    phase_d = (phase_q == PH_WR) ? PH_RD : PH_DONE;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            default: state_d = S_PWR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_PWR;
            ret_q      <= S_IDLE;
            cnt_q      <= C_INIT;
            phase_q    <= PH_WR;
            w_q        <= '0;
            cmd_q      <= 4'b1111;
            ba_q       <= '0;
            a_q        <= '0;
            dqm_q      <= 2'b11;
            cke_q      <= 1'b0;
            dq_oe_q    <= 1'b0;
            rd_sr_q    <= '0;
            cmp_vld_q  <= 1'b0;
            ref_cnt_q  <= '0;
            ref_run_q  <= 1'b0;
            ref_pend_q <= 1'b0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            w_q       <= w_d;
            cmd_q     <= cmd_d;
            ba_q      <= ba_d;
            a_q       <= a_d;
            dqm_q     <= dqm_d;
            cke_q     <= 1'b1;
            dq_oe_q   <= dq_oe_d;
            // Bit k marks a READ k cycles on the pins; bit CL means data is valid now.
            rd_sr_q   <= {rd_sr_q[CL-1:0], rd_start};
            cmp_vld_q <= rd_sr_q[CL];
            if (cmp_vld_q && (rdata_q != exp_q)) error_q <= 1'b1;
            done_q    <= (phase_q == PH_DONE);
            if (ref_start) ref_run_q <= 1'b1;
            if (ref_clr)   ref_pend_q <= 1'b0;
            // Free-running interval timer; a set in the same cycle as a clear wins.
            if (ref_run_q) begin
                if (ref_cnt_q == C_REFI) begin
                    ref_cnt_q  <= '0;
                    ref_pend_q <= 1'b1;
                end else begin
                    ref_cnt_q <= ref_cnt_q + 1'b1;
                end
            end
        end
    end

    // Data-path registers carry no reset; their qualifiers above do.
    always_ff @(posedge clk) begin
        dout_q <= dout_d;
        exp_q  <= exp_d;
        if (rd_sr_q[CL]) rdata_q <= sdram_dq_io;
    end

    assign sdram_cs_n_o  = cmd_q[3];
    assign sdram_ras_n_o = cmd_q[2];
    assign sdram_cas_n_o = cmd_q[1];
    assign sdram_we_n_o  = cmd_q[0];
    assign sdram_ba_o    = ba_q;
    assign sdram_a_o     = a_q;
    assign sdram_dqm_o   = dqm_q;
    assign sdram_cke_o   = cke_q;
    assign sdram_dq_io   = dq_oe_q ? dout_q : 16'hzzzz;
    assign error_o       = error_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_sdram_selftest.sv
module tb_sdram_selftest;

    localparam int N    = 520;
    localparam int REFI = 781;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        cs_n, ras_n, cas_n, we_n;
    wire  [15:0] dq;
    logic [1:0]  dqm;
    logic        cke, err, done;
    logic [15:0] drv_v = '0;
    logic        drv_en = 1'b0;

    assign dq = drv_en ? drv_v : 16'hzzzz;

    always #5 clk = ~clk;

    sdram_selftest #(
        .SDRAM_CLK_FREQ_MHZ(100),
        .INIT_US(1),
        .TEST_WORDS(N)
    ) dut (
        .clk(clk),
        .reset_n_i(rst_n),
        .sdram_ba_o(ba),
        .sdram_a_o(a),
        .sdram_cs_n_o(cs_n),
        .sdram_ras_n_o(ras_n),
        .sdram_cas_n_o(cas_n),
        .sdram_we_n_o(we_n),
        .sdram_dq_io(dq),
        .sdram_dqm_o(dqm),
        .sdram_cke_o(cke),
        .error_o(err),
        .done_o(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected word order for the write and read passes.
    logic [23:0] wq[$];
    logic [23:0] rq[$];
    logic [15:0] mem[logic [23:0]];

    bit          mon_en = 1'b0;
    bit          corrupt = 1'b0;
    bit          act_open;
    logic [12:0] act_row;
    logic [3:0]  cmd;
    logic [23:0] w;
    logic [23:0] addr;
    logic [15:0] model_v;
    int cyc, ninit, last_cmd, act_cyc, nwr, nrd, nref, last_ref, max_gap;
    int bus_bad, cke_bad, after_done_bad;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            cmd = {cs_n, ras_n, cas_n, we_n};
            if (cke !== 1'b1) cke_bad++;
            if (dut.dq_oe_q !== (cmd == C_WR)) bus_bad++;
            if (ninit < 4) begin
                if (cmd != C_NOP) begin
                    case (ninit)
                        0: begin
                            chk("init_pre", cmd, C_PRE);
                            chk("init_pre_a10", a[10], 1);
                            chk("init_nop_cycles", cyc - 1, 100);
                        end
                        1: begin
                            chk("init_ref1", cmd, C_REF);
                            chk("gap_trp", (cyc - last_cmd) >= 2, 1);
                        end
                        2: begin
                            chk("init_ref2", cmd, C_REF);
                            chk("gap_trfc1", (cyc - last_cmd) >= 7, 1);
                        end
                        default: begin
                            chk("init_mrs", cmd, C_MRS);
                            chk("gap_trfc2", (cyc - last_cmd) >= 7, 1);
                            chk("mrs_a", a, 13'h020);
                            chk("mrs_ba", ba, 0);
                            chk("mrs_dqm", dqm, 0);
                            last_ref = cyc;
                        end
                    endcase
                    ninit++;
                    last_cmd = cyc;
                end
            end else begin
                if (done && cmd != C_NOP && cmd != C_REF) after_done_bad++;
                case (cmd)
                    C_NOP: ;
                    C_ACT: begin
                        chk("act_while_open", act_open, 0);
                        act_open = 1'b1;
                        act_row  = a;
                        act_cyc  = cyc;
                    end
                    C_WR: begin
                        chk("wr_after_act", act_open, 1);
                        chk("wr_trcd", (cyc - act_cyc) >= 2, 1);
                        chk("wr_expected", wq.size() != 0, 1);
                        if (wq.size() != 0) begin
                            w = wq.pop_front();
                            chk("wr_ba", ba, w[23:22]);
                            chk("wr_row", act_row, w[21:9]);
                            chk("wr_a", a, {4'b0010, w[8:0]});
                            chk("wr_dq", dq, w[15:0] ^ 16'hA5A5);
                            chk("wr_dqm", dqm, 0);
                            if (w == 24'd512) begin
                                chk("w512_row", act_row, 1);
                                chk("w512_a", a, 13'h0400);
                            end
                        end
                        mem[{ba, act_row, a[8:0]}] = dq;
                        act_open = 1'b0;
                        nwr++;
                    end
                    C_RD: begin
                        chk("rd_after_act", act_open, 1);
                        chk("rd_trcd", (cyc - act_cyc) >= 2, 1);
                        chk("rd_expected", rq.size() != 0, 1);
                        if (rq.size() != 0) begin
                            w = rq.pop_front();
                            chk("rd_ba", ba, w[23:22]);
                            chk("rd_row", act_row, w[21:9]);
                            chk("rd_a", a, {4'b0010, w[8:0]});
                        end
                        if (nrd == 5) chk("err_before_w5", err, 0);
                        if (nrd == 6) chk("err_after_w5", err, corrupt);
                        addr    = {ba, act_row, a[8:0]};
                        model_v = mem.exists(addr) ? mem[addr] : 16'hDEAD;
                        if (corrupt && addr == 24'd5) model_v = 16'h0000;
                        // CL=2: data valid from just after the second edge, held over the third.
                        fork
                            automatic logic [15:0] vv = model_v;
                            begin
                                @(posedge clk);
                                @(posedge clk);
                                #1;
                                drv_v  = vv;
                                drv_en = 1'b1;
                                @(posedge clk);
                                #1;
                                drv_en = 1'b0;
                            end
                        join_none
                        act_open = 1'b0;
                        nrd++;
                    end
                    C_REF: begin
                        chk("ref_in_access", act_open, 0);
                        if ((cyc - last_ref) > max_gap) max_gap = cyc - last_ref;
                        last_ref = cyc;
                        nref++;
                    end
                    default: chk("bad_cmd", cmd, C_NOP);
                endcase
            end
        end
    end

    task automatic check_reset();
        chk("rst_cmd", {cs_n, ras_n, cas_n, we_n}, 4'hF);
        chk("rst_ba", ba, 0);
        chk("rst_a", a, 0);
        chk("rst_dqm", dqm, 2'b11);
        chk("rst_cke", cke, 0);
        chk("rst_dq_oe", dut.dq_oe_q, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
    endtask

    task automatic start_run();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        wq.delete();
        rq.delete();
        mem.delete();
        for (int i = 0; i < N; i++) begin
            wq.push_back(24'(i));
            rq.push_back(24'(i));
        end
        cyc = 0; ninit = 0; last_cmd = 0; act_cyc = 0; act_open = 1'b0;
        nwr = 0; nrd = 0; nref = 0; last_ref = 0; max_gap = 0;
        bus_bad = 0; cke_bad = 0; after_done_bad = 0;
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic finish_run();
        int t = 0;
        while (done !== 1'b1 && t < 30000) begin
            @(negedge clk);
            t++;
        end
        chk("done_reached", done, 1);
        repeat (1000) @(negedge clk);
        chk("err_final", err, corrupt);
        chk("done_held", done, 1);
        chk("init_cmds", ninit, 4);
        chk("write_count", nwr, N);
        chk("read_count", nrd, N);
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        chk("bus_z_outside_write", bus_bad, 0);
        chk("cke_high", cke_bad, 0);
        chk("ref_gap_bound", max_gap <= REFI + 16, 1);
        chk("refs_seen", nref >= 8, 1);
        chk("cmds_after_done", after_done_bad, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset();

        start_run();
        finish_run();

        // Reset in the middle of the write pass.
        begin
            int t = 0;
            start_run();
            while (nwr < 100 && t < 5000) begin
                @(negedge clk);
                t++;
            end
            chk("mid_write_reached", nwr >= 100, 1);
            @(posedge clk);
            #2;
            mon_en = 1'b0;
            rst_n  = 1'b0;
            #1;
            check_reset();
        end
        start_run();
        finish_run();

        corrupt = 1'b1;
        start_run();
        finish_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
